// File: rtl/if_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// if_fetch_unit_if
// Instruction-memory request/acknowledge bus between the fetch stage and
// instruction memory.
//   imem_req   : fetch stage requests the word at imem_addr
//   imem_addr  : word address of the request
//   imem_ack   : memory accepted the request; imem_rdata is valid this cycle
//   imem_rdata : instruction word returned with imem_ack
// Modports:
//   master : fetch stage side (drives req/addr)
//   slave  : memory side (drives ack/rdata)
// ---------------------------------------------------------------------------
interface if_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch stage of the 5-stage RV32I pipeline. Owns the program
// counter, fetches words over the imem req/ack bus and presents each fetched
// instruction with its address to the IF/ID register. Applies hazard stalls
// and taken-branch redirects; a redirect produces a one-cycle squash pulse so
// IF/ID loads a NOP.
//
// Configuration macro: IF_ALIGN_CHECK_EN
//   defined   : a misaligned branch target sets the sticky fetch_misalign_o
//               flag, suppresses the squash pulse and halts fetching (after
//               any outstanding request is acknowledged) until reset.
//   undefined : branch target bits [1:0] are forced to zero, fetch_misalign_o
//               is tied low.
//
// Ports:
//   clk_i            : clock, all state updates on rising edge
//   rst_ni           : synchronous active-low reset
//   stall_i          : hazard unit stall, IF/ID does not load this cycle
//   branch_taken_i   : one-cycle redirect request from EX
//   branch_target_i  : redirect PC, valid with branch_taken_i
//   imem             : instruction memory bus (master side)
//   fetch_valid_o    : iaddr_o/idata_o hold an unconsumed instruction
//   iaddr_o          : PC of the presented instruction
//   idata_o          : presented instruction word
//   pc_replace_o     : squash pulse to IF/ID
//   fetch_misalign_o : sticky misaligned-target flag
// ---------------------------------------------------------------------------
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    stall_i,
   input  logic                    branch_taken_i,
   input  logic [31:0]             branch_target_i,
   if_fetch_unit_if.master         imem,
   output logic                    fetch_valid_o,
   output logic [31:0]             iaddr_o,
   output logic [31:0]             idata_o,
   output logic                    pc_replace_o,
   output logic                    fetch_misalign_o
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      HOLD,
      FLUSH,
      HALT
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        req_q, req_d;
   logic [31:0] addr_q, addr_d;
   logic        valid_q, valid_d;
   logic [31:0] iaddr_q, iaddr_d;
   logic [31:0] idata_q, idata_d;
   logic        replace_q, replace_d;
   logic        misalign_q, misalign_d;

   logic [31:0] redirectPc;
   logic        misTarget;
   logic        consume;
   logic        outstanding;

   // The redirect address actually used. Without the alignment check the
   // low two bits are simply cleared; with it they are kept and a non-zero
   // value marks the redirect as misaligned.
`ifdef IF_ALIGN_CHECK_EN
   assign redirectPc = branch_target_i;
   assign misTarget  = |branch_target_i[1:0];
`else
   assign redirectPc = branch_target_i & ~32'h0000_0003;
   assign misTarget  = 1'b0;
`endif

   // IF/ID takes the presented instruction whenever it is valid and the
   // hazard unit is not stalling. A request is still in flight when we are
   // waiting on memory and the ack has not arrived this cycle.
   assign consume     = valid_q & ~stall_i;
   assign outstanding = ((state_q == FETCH) || (state_q == FLUSH)) & ~imem.imem_ack;

   // Next-state and output logic. Every register defaults to holding its
   // value and the squash pulse defaults low; the per-state behaviour is
   // computed first and a redirect then overrides it, since a taken branch
   // has priority over both stall and an arriving ack.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      valid_d    = valid_q;
      iaddr_d    = iaddr_q;
      idata_d    = idata_q;
      replace_d  = 1'b0;
      misalign_d = misalign_q;

      case (state_q)
         IDLE: begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
         end
         FETCH: begin
            if (consume) begin
               valid_d = 1'b0;
            end
            if (imem.imem_ack) begin
               iaddr_d = pc_q;
               idata_d = imem.imem_rdata;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
               if (stall_i) begin
                  state_d = HOLD;
                  req_d   = 1'b0;
               end else begin
                  addr_d  = pc_q + 32'd4;
               end
            end
         end
         HOLD: begin
            if (!stall_i) begin
               valid_d = 1'b0;
               state_d = FETCH;
               req_d   = 1'b1;
               addr_d  = pc_q;
            end
         end
         FLUSH: begin
            if (imem.imem_ack) begin
               state_d = misalign_q ? HALT : FETCH;
               req_d   = ~misalign_q;
               addr_d  = pc_q;
            end
         end
         HALT: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase

      // A request already on the bus cannot be withdrawn, so with one in
      // flight we park in FLUSH holding req/addr until the ack drains.
      if (branch_taken_i && (state_q != HALT)) begin
         pc_d    = redirectPc;
         valid_d = 1'b0;
         if (misTarget) begin
            misalign_d = 1'b1;
         end else begin
            replace_d  = 1'b1;
         end
         if (outstanding) begin
            state_d = FLUSH;
            req_d   = 1'b1;
            addr_d  = addr_q;
         end else if (misTarget || misalign_q) begin
            state_d = HALT;
            req_d   = 1'b0;
         end else begin
            state_d = FETCH;
            req_d   = 1'b1;
            addr_d  = redirectPc;
         end
      end
   end

   // State and output registers with synchronous active-low reset. Reset
   // drops any outstanding memory request and presents a NOP.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         valid_q    <= 1'b0;
         iaddr_q    <= 32'h0000_0000;
         idata_q    <= NOP;
         replace_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         valid_q    <= valid_d;
         iaddr_q    <= iaddr_d;
         idata_q    <= idata_d;
         replace_q  <= replace_d;
         misalign_q <= misalign_d;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = addr_q;
   assign fetch_valid_o  = valid_q;
   assign iaddr_o        = iaddr_q;
   assign idata_o        = idata_q;
   assign pc_replace_o   = replace_q;

`ifdef IF_ALIGN_CHECK_EN
   assign fetch_misalign_o = misalign_q;
`else
   assign fetch_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_unit
// Testbench for if_fetch_unit. A memory model answers requests with a word
// derived from the address; expected fetched instructions go into a queue as
// stimulus is issued and a monitor pops them whenever IF/ID consumes one.
// Direct checks cover reset values, request addresses and the squash pulse.
// Expected values for the misaligned-target case follow IF_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_if_fetch_unit;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        rstN;
   logic        stall;
   logic        branchTaken;
   logic [31:0] branchTarget;
   logic        ackEn;
   logic        fetchValid;
   logic [31:0] iaddr;
   logic [31:0] idata;
   logic        pcReplace;
   logic        fetchMisalign;

   int   checks;
   int   failures;
   exp_t expQ[$];
   exp_t popped;

   if_fetch_unit_if bus ();

   if_fetch_unit #(
      .RESET_PC(32'h0000_0000)
   ) dut (
      .clk_i            (clk),
      .rst_ni           (rstN),
      .stall_i          (stall),
      .branch_taken_i   (branchTaken),
      .branch_target_i  (branchTarget),
      .imem             (bus),
      .fetch_valid_o    (fetchValid),
      .iaddr_o          (iaddr),
      .idata_o          (idata),
      .pc_replace_o     (pcReplace),
      .fetch_misalign_o (fetchMisalign)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Zero-wait memory: acks a pending request whenever ackEn is high.
   assign bus.imem_ack   = ackEn & bus.imem_req;
   assign bus.imem_rdata = memWord(bus.imem_addr);

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs, then return 1 ns after the sampling edge.
   task automatic applyStimulus(input logic st, input logic br,
                                input logic [31:0] tgt, input logic ack);
      stall        = st;
      branchTaken  = br;
      branchTarget = tgt;
      ackEn        = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic expectFetch(input logic [31:0] a);
      exp_t e;
      e.addr = a;
      e.data = memWord(a);
      expQ.push_back(e);
   endtask

   // Monitor: whenever IF/ID is about to consume an instruction, compare it
   // with the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk);
         if (rstN === 1'b1 && fetchValid === 1'b1 && stall === 1'b0) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_fetch actual=%h required=none", iaddr);
            end else begin
               popped = expQ.pop_front();
               checkOutput("fetch_iaddr", iaddr, popped.addr);
               checkOutput("fetch_idata", idata, popped.data);
            end
         end
      end
   end

   initial begin
      checks       = 0;
      failures     = 0;
      rstN         = 1'b0;
      stall        = 1'b0;
      branchTaken  = 1'b0;
      branchTarget = 32'h0;
      ackEn        = 1'b0;

      // Reset values
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("rst_req",      {31'b0, bus.imem_req}, 32'd0);
      checkOutput("rst_addr",     bus.imem_addr, 32'h0);
      checkOutput("rst_valid",    {31'b0, fetchValid}, 32'd0);
      checkOutput("rst_iaddr",    iaddr, 32'h0);
      checkOutput("rst_idata",    idata, 32'h0000_0013);
      checkOutput("rst_replace",  {31'b0, pcReplace}, 32'd0);
      checkOutput("rst_misalign", {31'b0, fetchMisalign}, 32'd0);

      // Release: IDLE -> FETCH at address 0
      rstN = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("idle_req",  {31'b0, bus.imem_req}, 32'd1);
      checkOutput("idle_addr", bus.imem_addr, 32'h0);

      // Back-to-back zero-wait fetches 0,4,8,12,16
      for (int i = 0; i < 5; i++) begin
         expectFetch(32'(i * 4));
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
         checkOutput("stream_addr", bus.imem_addr, 32'(i * 4 + 4));
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("drain_valid", {31'b0, fetchValid}, 32'd0);

      // Stall for three cycles; the first carries the ack for 20
      expectFetch(32'd20);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("hold_req",   {31'b0, bus.imem_req}, 32'd0);
      checkOutput("hold_valid", {31'b0, fetchValid}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      checkOutput("hold_iaddr", iaddr, 32'd20);
      checkOutput("hold_req2",  {31'b0, bus.imem_req}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("bubble_valid", {31'b0, fetchValid}, 32'd0);
      checkOutput("bubble_addr",  bus.imem_addr, 32'd24);
      expectFetch(32'd24);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

      // Redirect to 0x100 while request for 28 waits; ack two cycles later
      applyStimulus(1'b0, 1'b1, 32'h100, 1'b0);
      checkOutput("flush_replace", {31'b0, pcReplace}, 32'd1);
      checkOutput("flush_valid",   {31'b0, fetchValid}, 32'd0);
      checkOutput("flush_addr",    bus.imem_addr, 32'd28);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("flush_replace_off", {31'b0, pcReplace}, 32'd0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("flush_done_addr",  bus.imem_addr, 32'h100);
      checkOutput("flush_done_valid", {31'b0, fetchValid}, 32'd0);
      expectFetch(32'h100);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

      // Redirect together with stall and ack: redirect wins
      applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
      checkOutput("prio_valid",   {31'b0, fetchValid}, 32'd0);
      checkOutput("prio_addr",    bus.imem_addr, 32'h200);
      checkOutput("prio_replace", {31'b0, pcReplace}, 32'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("prio_replace_off", {31'b0, pcReplace}, 32'd0);

      // PC wrap at the top of the address space
      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
      checkOutput("wrap_target", bus.imem_addr, 32'hFFFF_FFF8);
      expectFetch(32'hFFFF_FFF8);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("wrap_addr_fc", bus.imem_addr, 32'hFFFF_FFFC);
      expectFetch(32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("wrap_addr_0", bus.imem_addr, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

      // Misaligned redirect target 0x102
      applyStimulus(1'b0, 1'b1, 32'h102, 1'b1);
`ifdef IF_ALIGN_CHECK_EN
      checkOutput("mis_flag",    {31'b0, fetchMisalign}, 32'd1);
      checkOutput("mis_req",     {31'b0, bus.imem_req}, 32'd0);
      checkOutput("mis_replace", {31'b0, pcReplace}, 32'd0);
      applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
      checkOutput("halt_req",   {31'b0, bus.imem_req}, 32'd0);
      checkOutput("halt_valid", {31'b0, fetchValid}, 32'd0);
      checkOutput("halt_flag",  {31'b0, fetchMisalign}, 32'd1);
`else
      checkOutput("mis_addr",    bus.imem_addr, 32'h100);
      checkOutput("mis_req",     {31'b0, bus.imem_req}, 32'd1);
      checkOutput("mis_replace", {31'b0, pcReplace}, 32'd1);
      checkOutput("mis_flag",    {31'b0, fetchMisalign}, 32'd0);
      expectFetch(32'h100);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
`endif

      // Reset again clears everything, including the sticky flag
      rstN = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("rst2_misalign", {31'b0, fetchMisalign}, 32'd0);
      checkOutput("rst2_req",      {31'b0, bus.imem_req}, 32'd0);
      checkOutput("rst2_valid",    {31'b0, fetchValid}, 32'd0);
      checkOutput("rst2_idata",    idata, 32'h0000_0013);

      checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID pipeline register. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and presents each fetched instruction/address pair to IF/ID. Stalls from the hazard unit and taken-branch redirects from EX are applied here; a redirect also produces the squash pulse that makes IF/ID load a NOP (ADDI x0,x0,0 = 32'h0000_0013).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  hazard unit: IF/ID must not load this cycle
- branch_taken  in  1  one-cycle redirect request from EX
- branch_target  in  32  redirect PC, valid with branch_taken
- imem_req  out  1  instruction memory request
- imem_addr  out  32  request word address
- imem_ack  in  1  memory accepted request; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- fetch_valid  out  1  iaddr_out/idata_out hold an unconsumed instruction
- iaddr_out  out  32  PC of presented instruction
- idata_out  out  32  presented instruction
- pc_replace  out  1  squash pulse to IF/ID
- fetch_misalign  out  1  sticky misaligned-target flag (see Configuration)

## Operation
- Reset (rst_n=0 at posedge): pc=RESET_PC, state IDLE, imem_req=0, imem_addr=RESET_PC, fetch_valid=0, iaddr_out=0, idata_out=32'h0000_0013, pc_replace=0, fetch_misalign=0. Any outstanding memory request is abandoned.
- All outputs registered. Consume rule: IF/ID takes the instruction in any cycle with fetch_valid=1 and stall=0.
- States:
  - IDLE: next cycle -> FETCH (imem_req=1, imem_addr=pc).
  - FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack. On ack: iaddr_out=pc, idata_out=imem_rdata, fetch_valid=1, pc=pc+4. If stall=0: stay FETCH, requesting pc+4 next cycle (back-to-back, 1 instr/cycle at zero wait). If stall=1: -> HOLD, imem_req=0.
  - HOLD: imem_req=0; outputs frozen while stall=1. Cycle with stall=0: instruction consumed; next cycle fetch_valid=0, -> FETCH (one bubble).
  - FLUSH: redirect arrived while a request was outstanding; request cannot be withdrawn, so imem_req/imem_addr held until ack, returned data discarded, -> FETCH at redirected pc.
  - HALT: only with IF_ALIGN_CHECK_EN; imem_req=0, fetch_valid=0 until reset.
- Redirect (branch_taken=1), priority over stall and ack:
  - pc=branch_target; fetch_valid=0 next cycle; pc_replace=1 for exactly the next cycle.
  - From FETCH with imem_ack=0 -> FLUSH; with imem_ack=1 (same cycle) -> data discarded, -> FETCH at target.
  - From HOLD/IDLE -> FETCH at target. From FLUSH: target overwrites pc, remain FLUSH.
- Arithmetic: pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 0.

## Timing
- Zero-wait memory (ack same cycle as req): instruction at iaddr_out/idata_out one cycle after ack; sustained 1 instr/cycle.
- Redirect: target address on imem_addr one cycle after branch_taken (two+ if FLUSH waits for ack).
- Stall with data pending: one bubble cycle after release.
- pc_replace never asserted two consecutive cycles unless branch_taken is.

## Configuration
- IF_ALIGN_CHECK_EN defined: branch_target[1:0]!=0 sets fetch_misalign=1 (sticky until reset), no pc_replace for that redirect, -> HALT after any outstanding ack drains.
- Undefined: branch_target[1:0] silently forced to 2'b00; fetch_misalign tied 0; HALT unreachable.

## Test plan
- Reset release, RESET_PC=0, ack every cycle -> imem_addr 0,4,8,...; fetch_valid=1 continuously from cycle 2, iaddr_out tracks addresses.
- stall=1 for 3 cycles with ack -> outputs frozen on one instruction, imem_req=0; after release exactly one bubble then next PC fetched.
- branch_taken with target 32'h100 while FETCH awaits ack (ack 2 cycles later) -> pc_replace one-cycle pulse, late data discarded, next request addr 32'h100.
- branch_taken same cycle as stall=1 and ack -> redirect wins: data dropped, fetch_valid=0, imem_addr=target next cycle.
- pc=32'hFFFF_FFFC fetched -> next imem_addr 0.
- Target 32'h102: without macro imem_addr=32'h100; with IF_ALIGN_CHECK_EN fetch_misalign=1, imem_req=0 until rst_n=0.
